mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, data/address width.
REQ-002 SHALL have parameter DEPTH, default 32, words per memory array; valid addresses are 0..DEPTH-1.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 if_req  input  1  fetch request; held high until if_gnt.
REQ-006 if_addr  input  N  fetch word address.
REQ-007 if_gnt  output  1  one-cycle pulse, fetch request accepted.
REQ-008 if_valid  output  1  one-cycle pulse, if_rdata valid.
REQ-009 if_rdata  output  N  fetched instruction word.
REQ-010 d_req  input  1  data request; held high until d_gnt.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  N  data word address.
REQ-013 d_wdata  input  N  store data.
REQ-014 d_gnt  output  1  one-cycle pulse, data request accepted.
REQ-015 d_valid  output  1  one-cycle pulse, load data returned or store completed.
REQ-016 d_rdata  output  N  load data; 0 for stores.
REQ-017 err  output  1  one-cycle pulse coincident with a valid, address out of range.
REQ-018 memory_address  output  N  address to the shared memory.
REQ-019 write_data  output  N  store data to memory.
REQ-020 Memwrite  output  1  memory write strobe.
REQ-021 Memread  output  1  selects data array on memory read path.
REQ-022 memory_out  input  N  combinational read data from memory.

Function
REQ-023 FSM states SHALL be IDLE, ACCESS, RESP; IDLE->ACCESS on any grant, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-024 In IDLE with exactly one request high, that requester SHALL be granted that cycle (gnt pulse).
REQ-025 In IDLE with both requests high, grant SHALL go to the requester not granted last (round-robin via last_grant register).
REQ-026 At grant, requester ID, address, we and wdata SHALL be captured; requester inputs are don't-care afterwards.
REQ-027 No gnt SHALL be issued in ACCESS or RESP; requests arriving then wait, minimum 3 cycles between grants.
REQ-028 In ACCESS: memory_address = captured address; Memread = 1 only for in-range data load; Memwrite = 1 only for in-range data store; write_data = captured wdata.
REQ-029 Outside ACCESS, Memwrite, Memread, memory_address and write_data SHALL be 0.
REQ-030 At end of ACCESS, memory_out SHALL be registered into the response register (loads and fetches); stores register 0.
REQ-031 In RESP the owning requester's valid SHALL pulse with its rdata; latency grant-to-valid = 2 cycles.
REQ-032 Captured address >= DEPTH: no memory strobes in ACCESS, rdata = 0, err = 1 with valid.
REQ-033 if_rdata/d_rdata SHALL hold last value until next response of that requester.
REQ-034 if_gnt and d_gnt SHALL never be high in the same cycle; if_valid and d_valid likewise.

Reset
REQ-035 Reset SHALL force state IDLE, all outputs 0, response registers 0, last_grant = data (fetch wins first conflict).
REQ-036 Reset during ACCESS or RESP SHALL drop the transaction: no valid, no Memwrite after reset asserts.
REQ-037 After reset deassertion, a held request SHALL be granted in the first clock edge cycle.

Structure
REQ-038 Shared package mem_arb_pkg SHALL hold state encoding, requester IDs (REQ_IF=0, REQ_D=1) and default DEPTH.
REQ-039 The 2-way round-robin picker SHALL be sub-module arb_rr2 (inputs req[1:0], last; output grant id, grant valid).

Verification
REQ-040 Fetch only: if_req, if_addr=3, memory word 3 = 0x2129000A -> if_gnt cycle 0, if_valid with 0x2129000A cycle 2.
REQ-041 Store then load: d_we=1, d_addr=5, d_wdata=0xDEADBEEF; then load addr 5 -> Memwrite one cycle, later d_rdata=0xDEADBEEF.
REQ-042 Both request from reset continuously -> grants alternate IF, D, IF, D, each 3 cycles apart.
REQ-043 d_addr=32 load -> no Memread/Memwrite, d_valid with err=1, d_rdata=0.
REQ-044 Reset asserted in ACCESS of a store -> Memwrite drops at once, no d_valid, next grant after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared definitions for the two-requester memory arbiter:
//            FSM state encoding, requester identifiers and default depth.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Transaction sequencer states: grant in IDLE, drive memory in ACCESS,
  // return the response in RESP.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Requester identifiers as carried in the grant-id / last-grant bits.
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  // Words per memory array unless overridden at instantiation.
  localparam int DEFAULT_DEPTH = 32;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// ============================================================================
// Module   : arb_rr2
// Purpose  : Two-way round-robin picker. A lone request wins outright; when
//            both requesters are active the one not granted last wins.
// Ports    : req[1:0]  in  request vector, bit index = requester id
//            last      in  id of the previously granted requester
//            gnt_id    out id of the selected requester
//            gnt_valid out at least one request is active
// Revision : 1.0 - initial release
// ============================================================================
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_id,
  output logic       gnt_valid
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = REQ_IF;
    case (req)
      2'b01:   gnt_id = REQ_IF;
      2'b10:   gnt_id = REQ_D;
      // Conflict: hand the grant to whoever did not get it last time.
      2'b11:   gnt_id = ~last;
      default: gnt_id = REQ_IF;
    endcase
  end

endmodule : arb_rr2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one memory port between an instruction-fetch requester
//            and a data (load/store) requester. One transaction at a time,
//            three cycles each: grant (IDLE) -> memory access (ACCESS) ->
//            response pulse (RESP). Out-of-range addresses suppress the
//            memory strobes and return zero data with an error pulse.
// Ports    : clk, reset          clock / async active-high reset
//            if_req/if_addr      fetch request and word address
//            if_gnt/if_valid     fetch accept pulse / response pulse
//            if_rdata            last fetched word (held)
//            d_req/d_we/d_addr/d_wdata  data request, store flag, addr, data
//            d_gnt/d_valid       data accept pulse / response pulse
//            d_rdata             last load data (0 after a store, held)
//            err                 out-of-range flag, coincident with a valid
//            memory_address, write_data, Memwrite, Memread  memory port
//            memory_out          combinational read data from memory
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  // fetch requester
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic         if_gnt,
  output logic         if_valid,
  output logic [N-1:0] if_rdata,
  // data requester
  input  logic         d_req,
  input  logic         d_we,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  output logic         d_gnt,
  output logic         d_valid,
  output logic [N-1:0] d_rdata,
  output logic         err,
  // shared memory port
  output logic [N-1:0] memory_address,
  output logic [N-1:0] write_data,
  output logic         Memwrite,
  output logic         Memread,
  input  logic [N-1:0] memory_out
);

  localparam logic [N-1:0] C_DEPTH = N'(DEPTH);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_last;
  logic         r_id;
  logic         r_we;
  logic [N-1:0] r_addr;
  logic [N-1:0] r_wdata;
  logic         r_err;
  logic [N-1:0] r_if_rdata;
  logic [N-1:0] r_d_rdata;

  logic [1:0]   w_req;
  logic         w_gnt_id;
  logic         w_gnt_valid;
  logic         w_take;
  logic         w_in_range;

  // Requests are masked while reset is held so no grant pulse can appear
  // combinationally before the FSM is released.
  assign w_req      = {d_req, if_req} & {2{~reset}};
  assign w_take     = (r_state == ST_IDLE) && w_gnt_valid;
  assign w_in_range = (r_addr < C_DEPTH);

  arb_rr2 u_arb (
    .req       (w_req),
    .last      (r_last),
    .gnt_id    (w_gnt_id),
    .gnt_valid (w_gnt_valid)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs. All memory-port outputs stay zero outside ACCESS,
  // so an asynchronous reset (which forces IDLE) drops Memwrite at once.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    if_gnt         = 1'b0;
    d_gnt          = 1'b0;
    if_valid       = 1'b0;
    d_valid        = 1'b0;
    err            = 1'b0;
    memory_address = '0;
    write_data     = '0;
    Memwrite       = 1'b0;
    Memread        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_state_nxt = ST_ACCESS;
          if_gnt      = (w_gnt_id == REQ_IF);
          d_gnt       = (w_gnt_id == REQ_D);
        end
      end
      ST_ACCESS: begin
        w_state_nxt    = ST_RESP;
        memory_address = r_addr;
        write_data     = r_wdata;
        // Memread steers the memory mux to the data array; fetches leave it
        // low so the instruction array is read.
        Memwrite       = (r_id == REQ_D) && r_we  && w_in_range;
        Memread        = (r_id == REQ_D) && !r_we && w_in_range;
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
        if_valid    = (r_id == REQ_IF);
        d_valid     = (r_id == REQ_D);
        err         = r_err;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture at grant, response capture at the end of ACCESS.
  // Only the owning requester's read-data register is updated so the other
  // one keeps its last value.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last     <= REQ_D;
      r_id       <= REQ_IF;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_take) begin
        r_last <= w_gnt_id;
        r_id   <= w_gnt_id;
        if (w_gnt_id == REQ_D) begin
          r_we    <= d_we;
          r_addr  <= d_addr;
          r_wdata <= d_wdata;
        end else begin
          r_we    <= 1'b0;
          r_addr  <= if_addr;
          r_wdata <= '0;
        end
      end
      if (r_state == ST_ACCESS) begin
        r_err <= ~w_in_range;
        if (r_id == REQ_IF) begin
          r_if_rdata <= w_in_range ? memory_out : '0;
        end else begin
          r_d_rdata  <= (w_in_range && !r_we) ? memory_out : '0;
        end
      end
    end
  end

  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;

endmodule : mem_arbiter
`default_nettype wire
